// File: rtl/complex_nr_acc.sv
// rtl/complex_nr_acc.sv - accumulates ACC_LEN complex products into one complex sum
module complex_nr_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 4,
  parameter int GUARD_BITS = 4,
  localparam int AW        = 2*DATA_WIDTH + GUARD_BITS,
  localparam int CW        = $clog2(ACC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    sw_rst,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [4*DATA_WIDTH-1:0] res_data,
  output logic                    acc_val,
  input  logic                    acc_ready,
  output logic [2*AW-1:0]         acc_data,
  output logic [CW-1:0]           acc_cnt
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACC_LEN - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t state, next_state;

  logic [PW-1:0] prod_re, prod_im;
  logic [AW-1:0] ext_re, ext_im;
  logic [AW-1:0] sum_re, sum_im;
  logic [AW-1:0] new_re, new_im;
  logic          take;
  logic          last;

  // Split the product and sign-extend each half into the guard bits.
  assign prod_re = res_data[4*DATA_WIDTH-1:PW];
  assign prod_im = res_data[PW-1:0];
  assign ext_re  = {{GUARD_BITS{prod_re[PW-1]}}, prod_re};
  assign ext_im  = {{GUARD_BITS{prod_im[PW-1]}}, prod_im};
  assign new_re  = sum_re + ext_re;
  assign new_im  = sum_im + ext_im;
  assign take    = res_val & res_ready;
  assign last    = (acc_cnt == LAST_CNT);

  // State register; reset always returns to accumulation.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state <= ST_ACC;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; outputs depend on state (and reset) only.
  always_comb begin
    next_state = state;
    res_ready  = 1'b0;
    acc_val    = 1'b0;
    case (state)
      ST_ACC: begin
        res_ready = ~sw_rst;
        if (res_val && last) begin
          next_state = ST_OUT;
        end
      end
      ST_OUT: begin
        acc_val = 1'b1;
        if (acc_ready) begin
          next_state = ST_ACC;
        end
      end
      default: next_state = ST_ACC;
    endcase
  end

  // Partial sums, frame counter and the registered result; the result only
  // changes on the final product of a frame, so it holds through backpressure.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      sum_re   <= '0;
      sum_im   <= '0;
      acc_cnt  <= '0;
      acc_data <= '0;
    end else if (take) begin
      if (last) begin
        acc_data <= {new_re, new_im};
        sum_re   <= '0;
        sum_im   <= '0;
        acc_cnt  <= '0;
      end else begin
        sum_re   <= new_re;
        sum_im   <= new_im;
        acc_cnt  <= acc_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_complex_nr_acc.sv
// tb/tb_complex_nr_acc.sv - self-checking bench for complex_nr_acc
module tb_complex_nr_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sw_rst, res_val, res_ready, acc_val, acc_ready;
  logic [31:0] res_data;
  logic [39:0] acc_data;
  logic [2:0]  acc_cnt;

  logic        r1_val, r1_ready, a1_val, a1_ready;
  logic [31:0] r1_data;
  logic [39:0] a1_data;
  logic [0:0]  a1_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_LEN(4), .GUARD_BITS(4)) dut (
    .clk(clk), .sw_rst(sw_rst), .res_val(res_val), .res_ready(res_ready),
    .res_data(res_data), .acc_val(acc_val), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_cnt(acc_cnt)
  );

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_LEN(1), .GUARD_BITS(4)) dut1 (
    .clk(clk), .sw_rst(sw_rst), .res_val(r1_val), .res_ready(r1_ready),
    .res_data(r1_data), .acc_val(a1_val), .acc_ready(a1_ready),
    .acc_data(a1_data), .acc_cnt(a1_cnt)
  );

  // Pack a complex product {re, im} as 16-bit two's complement halves.
  function automatic logic [31:0] prod(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  // Reference: integer sums of the frame, truncated to the 20-bit fields.
  function automatic logic [39:0] model(input int re[4], input int im[4]);
    int sr = 0;
    int si = 0;
    for (int k = 0; k < 4; k++) begin
      sr += re[k];
      si += im[k];
    end
    return {sr[19:0], si[19:0]};
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Offer one product from a negedge and return at the negedge after it transfers.
  task automatic send(input int re, input int im);
    int waited = 0;
    res_val  = 1'b1;
    res_data = prod(re, im);
    #1;
    while (res_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (res_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: res_ready=%b required 1", res_ready);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    res_val = 1'b0;
  endtask

  task automatic idle(input int n);
    res_val = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    sw_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", res_ready); end
    n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL rst_val: got %b required 0", acc_val); end
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", acc_cnt); end
    n_checks++; if (acc_data !== 40'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", acc_data); end
    sw_rst = 1'b0;
    #1;
    n_checks++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", res_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL basic_early_val: got %b required 0", acc_val); end
      send(2, 16);
    end
    #1;
    n_checks++; if (acc_val !== 1'b1) begin n_fail++; $display("FAIL basic_val: got %b required 1", acc_val); end
    n_checks++; if (acc_data !== {20'd8, 20'd64}) begin n_fail++; $display("FAIL basic_data: got %h required %h", acc_data, {20'd8, 20'd64}); end
    @(negedge clk); #1;
    n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL basic_val_drop: got %b required 0", acc_val); end
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL basic_cnt: got %0d required 0", acc_cnt); end
  endtask

  task automatic test_extreme();
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(-32768, 32767);
    #1;
    n_checks++; if (acc_data !== {20'hE0000, 20'h1FFFC}) begin n_fail++; $display("FAIL extreme_data: got %h required %h", acc_data, {20'hE0000, 20'h1FFFC}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int re[4], im[4];
    logic [39:0] exp;
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      re[i] = rnd16(); im[i] = rnd16();
      send(re[i], im[i]);
    end
    exp = model(re, im);
    re[0] = rnd16(); im[0] = rnd16();
    res_val = 1'b1; res_data = prod(re[0], im[0]);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b required 0", c, res_ready); end
      n_checks++; if (acc_val !== 1'b1) begin n_fail++; $display("FAIL bp_val cycle %0d: got %b required 1", c, acc_val); end
      n_checks++; if (acc_data !== exp) begin n_fail++; $display("FAIL bp_data cycle %0d: got %h required %h", c, acc_data, exp); end
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready: got %b required 1", res_ready); end
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_resume_cnt: got %0d required 0", acc_cnt); end
    @(negedge clk); #1;
    res_val = 1'b0;
    n_checks++; if (acc_cnt !== 3'd1) begin n_fail++; $display("FAIL bp_first_accept: got %0d required 1", acc_cnt); end
    for (int i = 1; i < 4; i++) begin
      re[i] = rnd16(); im[i] = rnd16();
      send(re[i], im[i]);
    end
    exp = model(re, im);
    #1;
    n_checks++; if (acc_data !== exp) begin n_fail++; $display("FAIL bp_next_frame: got %h required %h", acc_data, exp); end
    @(negedge clk);
  endtask

  task automatic test_midframe_reset();
    acc_ready = 1'b1;
    send(100, 100);
    send(100, 100);
    #1;
    n_checks++; if (acc_cnt !== 3'd2) begin n_fail++; $display("FAIL mid_cnt_before: got %0d required 2", acc_cnt); end
    sw_rst = 1'b1;
    #1;
    n_checks++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_rst: got %b required 0", res_ready); end
    @(negedge clk);
    sw_rst = 1'b0;
    #1;
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_cnt_after: got %0d required 0", acc_cnt); end
    for (int i = 0; i < 4; i++) send(1, 1);
    #1;
    n_checks++; if (acc_data !== {20'd4, 20'd4}) begin n_fail++; $display("FAIL mid_data: got %h required %h", acc_data, {20'd4, 20'd4}); end
    @(negedge clk);
  endtask

  task automatic test_mixed_gaps();
    int re[4] = '{5, -7, 0, 1};
    int im[4] = '{-3, 2, 0, 1};
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (acc_cnt !== 3'(i)) begin n_fail++; $display("FAIL mixed_cnt %0d: got %0d required %0d", i, acc_cnt, i); end
      send(re[i], im[i]);
      if (i < 3) idle(1 + int'($urandom_range(0, 2)));
    end
    #1;
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL mixed_cnt_end: got %0d required 0", acc_cnt); end
    n_checks++; if (acc_data !== {20'hFFFFF, 20'h00000}) begin n_fail++; $display("FAIL mixed_data: got %h required %h", acc_data, {20'hFFFFF, 20'h00000}); end
    n_checks++; if (acc_data !== model(re, im)) begin n_fail++; $display("FAIL mixed_model: got %h required %h", acc_data, model(re, im)); end
    @(negedge clk);
  endtask

  task automatic test_reset_cases();
    int re[4] = '{3, -4, 9, 100};
    int im[4] = '{-1, 7, 2, -50};
    acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(7, 7);
    res_val = 1'b1; res_data = prod(7, 7); sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0; res_val = 1'b0;
    #1;
    n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL prio_val: got %b required 0", acc_val); end
    n_checks++; if (acc_cnt !== 3'd0) begin n_fail++; $display("FAIL prio_cnt: got %0d required 0", acc_cnt); end
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(5, 5);
    #1;
    n_checks++; if (acc_val !== 1'b1) begin n_fail++; $display("FAIL out_rst_pre: got %b required 1", acc_val); end
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    #1;
    n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL out_rst_val: got %b required 0", acc_val); end
    n_checks++; if (acc_data !== 40'h0) begin n_fail++; $display("FAIL out_rst_data: got %h required 0", acc_data); end
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(re[i], im[i]);
    #1;
    n_checks++; if (acc_data !== model(re, im)) begin n_fail++; $display("FAIL post_rst_frame: got %h required %h", acc_data, model(re, im)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int re[4], im[4];
    int waited;
    logic [39:0] exp;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) begin
        re[i] = rnd16(); im[i] = rnd16();
        acc_ready = 1'($urandom_range(0, 1));
        send(re[i], im[i]);
        if (i < 3) idle(int'($urandom_range(0, 2)));
      end
      exp = model(re, im);
      waited = 0;
      acc_ready = 1'($urandom_range(0, 1));
      while (1) begin
        #1;
        n_checks++; if (acc_val !== 1'b1) begin n_fail++; $display("FAIL rand_val frame %0d: got %b required 1", f, acc_val); end
        n_checks++; if (acc_data !== exp) begin n_fail++; $display("FAIL rand_data frame %0d: got %h required %h", f, acc_data, exp); end
        if (acc_ready) break;
        @(negedge clk);
        waited++;
        acc_ready = (waited >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk); #1;
      n_checks++; if (acc_val !== 1'b0) begin n_fail++; $display("FAIL rand_drop frame %0d: got %b required 0", f, acc_val); end
    end
  endtask

  task automatic test_acc_len1();
    r1_val = 1'b1; r1_data = prod(-1, 1); a1_ready = 1'b1;
    #1;
    n_checks++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL len1_ready: got %b required 1", r1_ready); end
    @(negedge clk);
    r1_val = 1'b0;
    #1;
    n_checks++; if (a1_val !== 1'b1) begin n_fail++; $display("FAIL len1_val: got %b required 1", a1_val); end
    n_checks++; if (a1_data !== {20'hFFFFF, 20'h00001}) begin n_fail++; $display("FAIL len1_data: got %h required %h", a1_data, {20'hFFFFF, 20'h00001}); end
    n_checks++; if (a1_cnt !== 1'b0) begin n_fail++; $display("FAIL len1_cnt: got %0d required 0", a1_cnt); end
    @(negedge clk); #1;
    n_checks++; if (a1_val !== 1'b0) begin n_fail++; $display("FAIL len1_drop: got %b required 0", a1_val); end
  endtask

  initial begin
    sw_rst = 1'b1; res_val = 1'b0; res_data = '0; acc_ready = 1'b1;
    r1_val = 1'b0; r1_data = '0; a1_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extreme();
    test_backpressure();
    test_midframe_reset();
    test_mixed_gaps();
    test_reset_cases();
    test_random();
    test_acc_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/complex_nr_acc.md
COMPLEX_NR_ACC -- requirements
Module: complex_nr_acc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (clock) and sw_rst (reset); no other reset input.
REQ-002 Parameter DATA_WIDTH, default 8: operand width of the upstream multiplier.
REQ-003 Parameter ACC_LEN, default 4: number of products summed per output; legal range 1..2^GUARD_BITS.
REQ-004 Parameter GUARD_BITS, default 4: extra accumulator MSBs; AW = 2*DATA_WIDTH+GUARD_BITS.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 sw_rst  in  1  synchronous reset, active 1.
REQ-007 res_val  in  1  upstream product valid.
REQ-008 res_ready  out  1  block accepts a product this cycle.
REQ-009 res_data  in  4*DATA_WIDTH  {re, im}; each 2*DATA_WIDTH signed two's complement, re in the MSBs.
REQ-010 acc_val  out  1  accumulated sum valid.
REQ-011 acc_ready  in  1  downstream consumer accepts the sum.
REQ-012 acc_data  out  2*AW  {sum_re, sum_im}; each AW signed, sum_re in the MSBs.
REQ-013 acc_cnt  out  $clog2(ACC_LEN+1)  products accepted in the current frame.

Function
REQ-014 A product transfers on a clk edge where res_val=1 and res_ready=1; a sum transfers on an edge where acc_val=1 and acc_ready=1.
REQ-015 The FSM SHALL have two states:
- ACC: res_ready=1, acc_val=0.
- OUT: res_ready=0, acc_val=1.
REQ-016 ACC, transfer with acc_cnt<ACC_LEN-1: sum_re/sum_im += sign-extended re/im; acc_cnt += 1.
REQ-017 ACC, transfer with acc_cnt=ACC_LEN-1: acc_data <= partial sum + current product; partial sum <= 0; acc_cnt <= 0; next state OUT.
REQ-018 Latency: acc_val SHALL assert on the cycle after the final product transfers.
REQ-019 OUT, acc_ready=1: next state ACC; acc_val deasserts the following cycle.
REQ-020 OUT, acc_ready=0: state, acc_val and acc_data SHALL hold unchanged for any number of cycles.
REQ-021 In OUT, res_val=1 SHALL NOT be accepted; the producer holds data until ACC resumes.
REQ-022 In ACC, acc_ready is ignored.
REQ-023 With no res_val in ACC, the partial sum and acc_cnt SHALL hold.
REQ-024 ACC_LEN=1: every product passes sign-extended to acc_data after 1 cycle; acc_cnt stays 0.
REQ-025 Arithmetic: two's complement, full AW width, no saturation; within ACC_LEN<=2^GUARD_BITS no overflow occurs.
REQ-026 Real and imaginary accumulation are independent and update on the same edge.
REQ-027 Outputs are driven from registers or the state only; no combinational path from res_val/acc_ready to any output.

Reset
REQ-028 sw_rst=1 at a clk edge SHALL set: state ACC, acc_cnt=0, partial sum=0, acc_data=0, acc_val=0.
REQ-029 res_ready SHALL be 0 while sw_rst=1 and 1 in the first cycle after release.
REQ-030 Reset mid-frame SHALL discard the partial sum.
REQ-031 Reset in OUT SHALL drop the pending sum without a transfer.
REQ-032 sw_rst SHALL take priority over any simultaneous transfer.

Verification (DATA_WIDTH=8, ACC_LEN=4, GUARD_BITS=4, AW=20)
REQ-033 Four products re=2, im=16 (from (2+3i)(4+2i)), res_val held high, acc_ready=1.
- acc_data = {20'd8, 20'd64}.
- acc_val high exactly 1 cycle, 1 cycle after the 4th transfer.
REQ-034 Four products re=-32768 (16'h8000), im=32767 (16'h7FFF).
- acc_data = {-131072, 131068}.
- Sign extension correct, no wrap.
REQ-035 Backpressure: acc_ready=0 for 5 cycles after acc_val rises, res_val held high with a new product.
- res_ready=0 and acc_data stable for all 5 cycles.
- First new product accepted 1 cycle after acc_ready=1.
REQ-036 Mid-frame reset: 2 products of 100+100i, then sw_rst for 1 cycle, then 4 products of 1+1i.
- acc_data = {4, 4}; acc_cnt reads 0 after reset.
REQ-037 Mixed signs with gaps: products 5-3i, -7+2i, 0+0i, 1+1i with res_val idle cycles between them.
- acc_data = {-1, 0}.
- acc_cnt sequence 0,1,2,3,0.
REQ-038 ACC_LEN=1 build: product -1+1i.
- acc_data = {20'hFFFFF, 20'h00001}, 1 cycle after the transfer.
